ultrasonic_sensor: RTL and testbench
====================================

ULTRASONIC_SENSOR -- requirements
Module: ultrasonic_sensor

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  CLK_HZ      100_000_000  system clock frequency
  TRIG_US     10           trigger pulse width, us
  US_PER_CM   58           echo microseconds per centimetre
  TIMEOUT_US  38000        max wait for echo rise and max echo-high time, us
  CYCLE_US    60000        trigger-start to next trigger-start period, us
REQ-002 Ports (name, direction, width, meaning):
  clk       input   1  system clock, rising edge
  reset     input   1  synchronous, active-low reset
  echo      input   1  asynchronous echo from HC-SR04-class sensor
  trigger   output  1  trigger pulse to the sensor
  distance  output  9  last measured distance, cm, unsigned
REQ-003 The design SHALL use one clock (clk) and a synchronous, active-low reset (reset); there are no other clock or reset inputs.

Function
REQ-004 A prescaler SHALL produce a 1-cycle 1 us tick every CLK_HZ/1_000_000 clocks; all timing SHALL count these ticks.
REQ-005 echo SHALL pass through a 2-flop synchronizer; rise/fall edges SHALL be detected on the synchronized signal.
REQ-006 FSM states: S_IDLE, S_TRIG, S_WAIT_ECHO, S_MEASURE.
REQ-007 S_IDLE -> S_TRIG when the cycle timer reaches CYCLE_US, or on the first clock after reset release; on entry to S_TRIG the cycle timer SHALL restart at 0.
REQ-008 S_TRIG: trigger=1 for exactly TRIG_US ticks (10 us ±1 tick), then trigger=0 and go to S_WAIT_ECHO.
REQ-009 trigger SHALL be 0 in every state other than S_TRIG, and SHALL be registered (glitch-free).
REQ-010 S_WAIT_ECHO: on synchronized echo rising edge -> S_MEASURE with us sub-counter and cm counter cleared; if TIMEOUT_US ticks elapse without a rise -> S_IDLE, distance unchanged.
REQ-011 S_MEASURE: on each tick a 0..US_PER_CM-1 sub-counter SHALL advance; on wrap it SHALL increment the cm counter, saturating at 511.
REQ-012 Result is floor(echo_high_us / US_PER_CM), clamped to 511; no divider SHALL be used.
REQ-013 On synchronized echo falling edge in S_MEASURE, distance SHALL load the cm counter within 4 clocks of the raw echo fall; FSM -> S_IDLE.
REQ-014 If echo stays high TIMEOUT_US ticks in S_MEASURE, distance SHALL load 511 and FSM -> S_IDLE.
REQ-015 distance SHALL change only at REQ-013/REQ-014 events and hold otherwise.
REQ-016 echo activity in S_IDLE or S_TRIG SHALL be ignored; an echo already high on entry to S_WAIT_ECHO SHALL NOT count as a rise.
REQ-017 The cycle timer SHALL saturate at CYCLE_US, so a measurement overrunning the period triggers immediately on return to S_IDLE.

Reset
REQ-018 While reset=0 at a clk edge: state=S_IDLE, trigger=0, distance=0, all counters and synchronizer flops cleared.
REQ-019 Reset asserted mid-trigger or mid-measurement SHALL abort immediately with no distance update; after release, trigger SHALL assert within 2 clocks.

Verification
REQ-020 Reset held low, echo=0 -> trigger=0, distance=0; release -> trigger rises within 2 clocks, stays high 1000 ±100 clocks at 100 MHz.
REQ-021 20 us after trigger falls, echo high 800 us -> distance=13 within 4 clocks of echo fall; trigger stays 0 until 60 ms after previous trigger rise.
REQ-022 Boundary: echo high 57 us -> distance=0; 58 us -> 1; 116 us -> 2.
REQ-023 No echo after trigger -> distance holds previous value; next trigger at 60 ms period.
REQ-024 Echo held high 40 ms -> distance=511 at 38 ms echo-high; echo fall later causes no further update.
REQ-025 Reset pulse during S_MEASURE (echo high 300 us) -> distance=0, trigger restarts after release, next 800 us echo -> 13.

Source files
------------

// File: rtl/ultrasonic_sensor.sv
// HC-SR04-class ranging controller: periodic trigger pulse, echo width
// measured in 1 us ticks and converted to centimetres by repeated counting.
module ultrasonic_sensor #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int TRIG_US    = 10,
    parameter int US_PER_CM  = 58,
    parameter int TIMEOUT_US = 38000,
    parameter int CYCLE_US   = 60000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       echo,
    output logic       trigger,
    output logic [8:0] distance
);

    localparam int DIV  = CLK_HZ / 1_000_000;
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int CW   = $clog2(CYCLE_US + 1);
    localparam int SW   = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [SW-1:0] sub_q, sub_d;
    logic [8:0]    cm_q, cm_d;
    logic [8:0]    dist_q, dist_d;
    logic          trig_q, trig_d;
    logic          start_q, start_d;
    logic [2:0]    sync_q, sync_d;

    logic          tick;
    logic          echo_rise;
    logic          echo_fall;
    logic [CW-1:0] cycle_inc;
    logic          sub_wrap;
    logic [8:0]    cm_inc;
    logic          trig_done;
    logic          timeout;

    assign tick      = (pre_q == PW'(DIV - 1));
    // sync_q[1] is the synchronized echo, sync_q[2] its previous value
    assign echo_rise = sync_q[1] & ~sync_q[2];
    assign echo_fall = ~sync_q[1] & sync_q[2];
    assign cycle_inc = (tick && cycle_q != CW'(CYCLE_US)) ? cycle_q + 1'b1 : cycle_q;
    assign sub_wrap  = tick && (sub_q == SW'(US_PER_CM - 1));
    assign cm_inc    = (sub_wrap && cm_q != 9'd511) ? cm_q + 1'b1 : cm_q;
    assign trig_done = tick && (timer_q == TW'(TRIG_US - 1));
    assign timeout   = tick && (timer_q == TW'(TIMEOUT_US - 1));

    always_comb begin
        state_d = state_q;
        pre_d   = tick ? '0 : pre_q + 1'b1;
        cycle_d = cycle_inc;
        timer_d = tick ? timer_q + 1'b1 : timer_q;
        sub_d   = sub_q;
        cm_d    = cm_q;
        dist_d  = dist_q;
        trig_d  = 1'b0;
        start_d = start_q;
        sync_d  = {sync_q[1:0], echo};

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (start_q || cycle_inc == CW'(CYCLE_US)) begin
                    // Realign the prescaler so the pulse is an exact number of ticks
                    state_d = S_TRIG;
                    trig_d  = 1'b1;
                    start_d = 1'b0;
                    cycle_d = '0;
                    pre_d   = '0;
                end
            end
            S_TRIG: begin
                trig_d = 1'b1;
                if (trig_done) begin
                    state_d = S_WAIT_ECHO;
                    trig_d  = 1'b0;
                    timer_d = '0;
                end
            end
            S_WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    sub_d   = '0;
                    cm_d    = '0;
                    timer_d = '0;
                    pre_d   = '0;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            S_MEASURE: begin
                if (tick) begin
                    sub_d = sub_wrap ? '0 : sub_q + 1'b1;
                    cm_d  = cm_inc;
                end
                // A tick landing on the fall cycle still counts toward the result
                if (echo_fall) begin
                    dist_d  = cm_inc;
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timeout) begin
                    dist_d  = 9'd511;
                    state_d = S_IDLE;
                    timer_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            cycle_q <= '0;
            timer_q <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
            dist_q  <= '0;
            trig_q  <= 1'b0;
            start_q <= 1'b1;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cycle_q <= cycle_d;
            timer_q <= timer_d;
            sub_q   <= sub_d;
            cm_q    <= cm_d;
            dist_q  <= dist_d;
            trig_q  <= trig_d;
            start_q <= start_d;
            sync_q  <= sync_d;
        end
    end

    assign trigger  = trig_q;
    assign distance = dist_q;

endmodule

// File: tb/tb_ultrasonic_sensor.sv
// Bench for ultrasonic_sensor at a scaled clock/period; expected distances
// come from floor(high_us / US_PER_CM) with timeout and clamp rules.
module tb_ultrasonic_sensor;

    localparam int CLK_HZ     = 2_000_000;
    localparam int TRIG_US    = 10;
    localparam int US_PER_CM  = 58;
    localparam int TIMEOUT_US = 1500;
    localparam int CYCLE_US   = 2000;
    localparam int DIV        = CLK_HZ / 1_000_000;
    localparam int PERIOD     = CYCLE_US * DIV;

    logic       clk;
    logic       reset;
    logic       echo;
    logic       trigger;
    logic [8:0] distance;

    int cyc      = 0;
    int n_tests  = 0;
    int n_fail   = 0;
    int rise_cyc = 0;
    int exp_dist = 0;

    ultrasonic_sensor #(
        .CLK_HZ    (CLK_HZ),
        .TRIG_US   (TRIG_US),
        .US_PER_CM (US_PER_CM),
        .TIMEOUT_US(TIMEOUT_US),
        .CYCLE_US  (CYCLE_US)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .echo    (echo),
        .trigger (trigger),
        .distance(distance)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_cm(input int high_us);
        int q;
        if (high_us > TIMEOUT_US) return 511;
        q = high_us / US_PER_CM;
        return (q > 511) ? 511 : q;
    endfunction

    task automatic wait_rise(input string tag, input int bound);
        int ok;
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (trigger === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check(tag, ok, 1);
        rise_cyc = cyc;
    endtask

    task automatic wait_fall();
        int ok;
        int width;
        ok = 0;
        for (int i = 0; i < (TRIG_US + 4) * DIV; i++) begin
            @(negedge clk);
            if (trigger === 1'b0) begin
                ok = 1;
                break;
            end
        end
        check("trig_fall", ok, 1);
        width = cyc - rise_cyc;
        check("trig_width_ok", (width >= (TRIG_US - 1) * DIV) && (width <= (TRIG_US + 1) * DIV), 1);
    endtask

    task automatic next_trig();
        int start;
        int period;
        start = rise_cyc;
        wait_rise("next_trig", PERIOD + 4 * DIV - (cyc - start));
        period = rise_cyc - start;
        check("period_ok", (period >= PERIOD - 2 * DIV) && (period <= PERIOD + 2 * DIV), 1);
    endtask

    task automatic run_meas(input int delay_us, input int high_us);
        int old;
        int h;
        int seg;
        wait_fall();
        old = exp_dist;
        h   = high_us * DIV;
        repeat (delay_us * DIV) @(posedge clk);
        #1 echo = 1'b1;
        if (high_us > TIMEOUT_US) begin
            seg = (TIMEOUT_US - 100) * DIV;
            repeat (seg) @(posedge clk);
            @(negedge clk);
            check("pre_timeout_hold", distance, old);
            repeat (h - seg - 1) @(posedge clk);
            @(negedge clk);
            check("timeout_sat", distance, 511);
        end else begin
            repeat (h - 1) @(posedge clk);
            @(negedge clk);
            check("hold_before_fall", distance, old);
        end
        @(posedge clk);
        #1 echo = 1'b0;
        exp_dist = ref_cm(high_us);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("dist_after_fall", distance, exp_dist);
    endtask

    task automatic run_noecho(input bit early_echo);
        if (early_echo) echo = 1'b1;
        wait_fall();
        if (early_echo) begin
            repeat (200 * DIV) @(posedge clk);
            #1 echo = 1'b0;
        end
        repeat ((early_echo ? 1400 : 1600) * DIV) @(posedge clk);
        @(negedge clk);
        check("noecho_hold", distance, exp_dist);
        repeat (100 * DIV) @(posedge clk);
        #1 echo = 1'b1;
        repeat (50 * DIV) @(posedge clk);
        #1 echo = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("idle_echo_ignored", distance, exp_dist);
    endtask

    initial begin
        int rel;
        reset = 1'b0;
        echo  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_trigger", trigger, 0);
        check("rst_distance", distance, 0);

        @(posedge clk);
        #1 reset = 1'b1;
        rel = cyc;
        wait_rise("trig_after_release", 4);
        check("release_latency_ok", (rise_cyc - rel >= 1) && (rise_cyc - rel <= 2), 1);

        run_meas(20, 800);   next_trig();
        run_meas(30, 57);    next_trig();
        run_meas(15, 58);    next_trig();
        run_meas(25, 116);   next_trig();
        run_noecho(1'b0);    next_trig();
        run_noecho(1'b1);    next_trig();
        run_meas(20, 1700);  next_trig();
        run_meas(20, 300);   next_trig();

        // Measurement overruns the period: trigger follows the result immediately
        run_meas(1000, 1200);
        wait_rise("overrun_retrigger", 8);

        for (int k = 0; k < 5; k++) begin
            run_meas($urandom_range(100, 5), $urandom_range(1400, 1));
            next_trig();
        end

        wait_fall();
        repeat (20 * DIV) @(posedge clk);
        #1 echo = 1'b1;
        repeat (300 * DIV) @(posedge clk);
        #1 begin
            reset = 1'b0;
            echo  = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort_distance", distance, 0);
        check("abort_trigger", trigger, 0);
        exp_dist = 0;
        @(posedge clk);
        #1 reset = 1'b1;
        rel = cyc;
        wait_rise("trig_after_abort", 4);
        check("abort_release_ok", (rise_cyc - rel >= 1) && (rise_cyc - rel <= 2), 1);
        run_meas(20, 800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
